// File: rtl/uart_pkg.sv
// Purpose : shared UART definitions (bit timing, receiver states, frame width).
// Latency : n/a (types, constants and elaboration-time functions only).
// Backpr. : n/a.
// Contents: DATA_BITS, rx_state_e, clks_per_bit(), half_bit().
package uart_pkg;

    // Payload bits per 8N1 frame.
    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_e;

    // Clocks per bit period. Integer division truncates, and uart_tx uses the
    // same truncation, so both ends agree exactly when run on the same clock.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    // Clocks from the start edge to the start-bit midpoint.
    function automatic int half_bit(input int clk_freq, input int baud);
        return clks_per_bit(clk_freq, baud) / 2;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Purpose : two-flop synchronizer for one asynchronous input.
// Latency : 2 clk cycles from d_i to q_o.
// Backpr. : none; q_o follows d_i every cycle.
// Ports   : clk_i clock, rst_i sync active-high reset (flops load RST_VAL),
//           d_i async input, q_o synchronized output.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {2{RST_VAL}};
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// Purpose : 8N1 UART receiver, LSB first, mid-bit sampling of a synchronized line.
// Latency : done 2 + HALF_BIT + 9*CLKS_PER_BIT + 1 cycles after the falling start edge.
// Backpr. : none; done/frame_err are one-cycle pulses and data holds until the next good frame.
// Ports   : clk, rst (sync active-high), rxd (async serial in, idle high),
//           data (last good byte), done / frame_err (pulses), busy (frame in progress).
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       done,
    output logic       frame_err,
    output logic       busy
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int HALF_BIT     = half_bit(CLK_FREQ, BAUD);
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int IDX_W        = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_BIT     = IDX_W'(DATA_BITS - 1);

    logic                 rxd_s;
    rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 done_q, done_d;
    logic                 frame_err_q, frame_err_d;

    // Line resets to the idle level so a reset does not look like a start edge.
    uart_sync2 #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (rxd),
        .q_o   (rxd_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            clk_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            data_q      <= '0;
            done_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            data_q      <= data_d;
            done_q      <= done_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q + CNT_W'(1);
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        data_d      = data_q;
        done_d      = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                if (!rxd_s) begin
                    state_d = START;
                end
            end

            START: begin
                // Re-check at the start-bit midpoint; a high line means the
                // falling edge was a glitch and is dropped silently.
                if (clk_cnt_q == CNT_HALF_END) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = rxd_s ? IDLE : DATA;
                end
            end

            DATA: begin
                // Counting a full bit from the start midpoint lands on each
                // data-bit midpoint.
                if (clk_cnt_q == CNT_BIT_END) begin
                    clk_cnt_d          = '0;
                    shreg_d[bit_idx_q] = rxd_s;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end

            STOP: begin
                // Leave at the stop midpoint so a back-to-back start edge half
                // a bit later is seen from IDLE.
                if (clk_cnt_q == CNT_BIT_END) begin
                    clk_cnt_d = '0;
                    if (rxd_s) begin
                        data_d  = shreg_q;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end
                end
            end

            BREAK: begin
                // A line still low after a bad stop bit is not a new start;
                // wait for it to return to idle first.
                clk_cnt_d = '0;
                if (rxd_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                clk_cnt_d = '0;
                state_d   = IDLE;
            end
        endcase
    end

    assign data      = data_q;
    assign done      = done_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Purpose : self-checking bench for uart_rx driven by a behavioural 8N1 transmitter.
// Latency : n/a.
// Backpr. : n/a.
module tb_uart_rx;

    // Small bit period keeps the run short: 50 clocks per bit, 25 to the midpoint.
    localparam int CLK_FREQ = 5000000;
    localparam int BAUD     = 100000;
    localparam int CPB      = CLK_FREQ / BAUD;
    localparam int HALF     = CPB / 2;
    // Transmitter bit periods in hundredths of a clock.
    localparam int PER_NOM  = CPB * 100;
    localparam int PER_FAST = (CPB * 10000) / 102;
    localparam int PER_SLOW = (CPB * 10000) / 98;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd;
    logic [7:0] data;
    logic       done;
    logic       frame_err;
    logic       busy;

    always #10 clk = ~clk;

    uart_rx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .data      (data),
        .done      (done),
        .frame_err (frame_err),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Edge counter and output monitor (sampled on the falling edge).
    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    logic [7:0]  rx_q[$];
    int          fe_cnt        = 0;
    int          both_cnt      = 0;
    int          long_cnt      = 0;
    int unsigned last_done_cyc = 0;
    logic        done_prev     = 1'b0;
    logic        fe_prev       = 1'b0;

    always @(negedge clk) begin
        if (done === 1'b1) begin
            rx_q.push_back(data);
            last_done_cyc = cyc;
        end
        if (frame_err === 1'b1) fe_cnt++;
        if (done === 1'b1 && frame_err === 1'b1) both_cnt++;
        if ((done === 1'b1 && done_prev) || (frame_err === 1'b1 && fe_prev)) long_cnt++;
        done_prev = (done === 1'b1);
        fe_prev   = (frame_err === 1'b1);
    end

    // Reference model: bytes a correct receiver must deliver, and the value
    // `data` must be holding.
    logic [7:0] exp_q[$];
    logic [7:0] model_data;

    // Serial transmitter; bit k starts at round(k * per_c / 100) clocks.
    task automatic tx_frame(input logic [7:0] b, input logic stop_v, input int per_c);
        logic [9:0] bits;
        bits = {stop_v, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            rxd = bits[k];
            repeat (((k + 1) * per_c + 50) / 100 - (k * per_c + 50) / 100) @(negedge clk);
        end
    endtask

    task automatic send(input logic [7:0] b, input int per_c);
        tx_frame(b, 1'b1, per_c);
        exp_q.push_back(b);
        model_data = b;
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_rx(input string tag, input int base, input int fe_base, input int exp_fe);
        int got;
        got = rx_q.size() - base;
        check_eq({tag, " bytes"}, 32'(got), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && base + i < rx_q.size(); i++)
            check_eq($sformatf("%s byte%0d", tag, i), 32'(rx_q[base + i]), 32'(exp_q[i]));
        check_eq({tag, " frame_err"}, 32'(fe_cnt - fe_base), 32'(exp_fe));
        check_eq({tag, " data"}, 32'(data), 32'(model_data));
        exp_q.delete();
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          b0;
        int          f0;
        int unsigned c0;
        logic [7:0]  rb;
        int          per;

        rst = 1'b1;
        rxd = 1'b1;
        model_data = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check_eq("reset data", 32'(data), 32'h00);
        check_eq("reset done", 32'(done), 32'h0);
        check_eq("reset frame_err", 32'(frame_err), 32'h0);
        check_eq("reset busy", 32'(busy), 32'h0);

        // Line held low out of reset: a frame of zeros with a bad stop bit.
        rst = 1'b1;
        rxd = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        b0 = rx_q.size(); f0 = fe_cnt;
        repeat (12 * CPB) @(negedge clk);
        check_eq("stuck-low busy", 32'(busy), 32'h1);
        check_rx("stuck-low", b0, f0, 1);
        idle(5);
        check_eq("stuck-low released busy", 32'(busy), 32'h0);

        // Single byte plus start-edge-to-done latency.
        b0 = rx_q.size(); f0 = fe_cnt;
        c0 = cyc;
        send(8'h55, PER_NOM);
        idle(CPB);
        check_rx("single 55", b0, f0, 0);
        check_eq("latency", last_done_cyc - c0, 32'(2 + HALF + 9 * CPB + 1));

        // Back-to-back frames.
        b0 = rx_q.size(); f0 = fe_cnt;
        send(8'h15, PER_NOM);
        send(8'hA3, PER_NOM);
        send(8'h00, PER_NOM);
        idle(CPB);
        check_rx("back-to-back", b0, f0, 0);

        // Glitch shorter than half a bit.
        b0 = rx_q.size(); f0 = fe_cnt;
        rxd = 1'b0;
        repeat (HALF / 2) @(negedge clk);
        check_eq("glitch busy", 32'(busy), 32'h1);
        idle(HALF + 4);
        check_eq("glitch idle", 32'(busy), 32'h0);
        check_rx("glitch", b0, f0, 0);

        // Framing error, line stays low two more bit times.
        b0 = rx_q.size(); f0 = fe_cnt;
        tx_frame(8'h3C, 1'b0, PER_NOM);
        repeat (2 * CPB) @(negedge clk);
        check_eq("break busy", 32'(busy), 32'h1);
        idle(5);
        check_eq("break released busy", 32'(busy), 32'h0);
        check_rx("framing error", b0, f0, 1);
        b0 = rx_q.size(); f0 = fe_cnt;
        send(8'h7E, PER_NOM);
        idle(CPB);
        check_rx("after framing error", b0, f0, 0);

        // Reset in the middle of data bit 4.
        b0 = rx_q.size(); f0 = fe_cnt;
        fork
            tx_frame(8'hF0, 1'b1, PER_NOM);
            begin
                repeat (5 * CPB + HALF + 2) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check_eq("mid reset busy", 32'(busy), 32'h0);
                check_eq("mid reset data", 32'(data), 32'h00);
                check_eq("mid reset done", 32'(done), 32'h0);
            end
        join
        model_data = 8'h00;
        idle(CPB);
        check_rx("mid reset", b0, f0, 0);
        b0 = rx_q.size(); f0 = fe_cnt;
        send(8'h81, PER_NOM);
        idle(CPB);
        check_rx("after reset", b0, f0, 0);

        // Transmitter 2% fast and 2% slow.
        b0 = rx_q.size(); f0 = fe_cnt;
        send(8'hFF, PER_FAST);
        send(8'h01, PER_FAST);
        send(8'hFF, PER_SLOW);
        send(8'h01, PER_SLOW);
        idle(CPB);
        check_rx("baud skew", b0, f0, 0);

        // Random bytes, random skew, random inter-frame gaps.
        b0 = rx_q.size(); f0 = fe_cnt;
        for (int i = 0; i < 12; i++) begin
            rb = 8'($urandom);
            case ($urandom_range(0, 2))
                0:       per = PER_FAST;
                1:       per = PER_SLOW;
                default: per = PER_NOM;
            endcase
            send(rb, per);
            idle($urandom_range(0, CPB));
        end
        idle(CPB);
        check_rx("random", b0, f0, 0);

        check_eq("done with frame_err", 32'(both_cnt), 32'h0);
        check_eq("pulse longer than one cycle", 32'(long_cnt), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
